// File: rtl/fetch_pkg.sv
// Shared types and default sizes for the instruction-fetch sequencer.
// The redirect record carries one execute-stage branch request.
package fetch_pkg;

    localparam int DEF_ADDR_W   = 6;
    localparam int DEF_INSTR_W  = 32;
    localparam int DEF_RESET_PC = 0;
    localparam int DEF_CNT_W    = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } fetch_state_e;

    typedef struct packed {
        logic                  valid;
        logic [DEF_ADDR_W-1:0] target;
        logic                  annul;
    } redirect_t;

endpackage

// File: rtl/pc_pair.sv
// PC/nPC register pair with wrap-around increment and a one-deep pending
// redirect latch; the redirect lands in npc so the delay slot is always fetched.
module pc_pair
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int RESET_PC = DEF_RESET_PC
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fire,
    input  redirect_t         br_in,
    output logic [ADDR_W-1:0] pc,
    output logic              redir_annul
);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] npc_q, npc_d;
    logic [ADDR_W-1:0] next_target;
    redirect_t         pend_q, pend_d;
    redirect_t         cur_redir;

    // A redirect arriving this cycle supersedes an older pending one.
    always_comb begin
        cur_redir   = br_in.valid ? br_in : pend_q;
        next_target = cur_redir.valid ? cur_redir.target : npc_q + 1'b1;
        redir_annul = cur_redir.valid & cur_redir.annul;
        pc_d        = pc_q;
        npc_d       = npc_q;
        pend_d      = pend_q;
        if (fire) begin
            pc_d   = npc_q;
            npc_d  = next_target;
            pend_d = '0;
        end else if (br_in.valid) begin
            pend_d = br_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q   <= ADDR_W'(RESET_PC);
            npc_q  <= ADDR_W'(RESET_PC + 1);
            pend_q <= '0;
        end else begin
            pc_q   <= pc_d;
            npc_q  <= npc_d;
            pend_q <= pend_d;
        end
    end

    assign pc = pc_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: drives imem_a from pc, registers the returned
// word into a one-entry valid/ready output stage, handles redirects and halt.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int INSTR_W  = DEF_INSTR_W,
    parameter int RESET_PC = DEF_RESET_PC,
    parameter int CNT_W    = DEF_CNT_W
) (
    input  logic               clk,
    input  logic               reset,
    output logic [ADDR_W-1:0]  imem_a,
    input  logic [INSTR_W-1:0] imem_rd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [ADDR_W-1:0]  out_pc,
    input  logic               br_valid,
    input  logic [ADDR_W-1:0]  br_target,
    input  logic               br_annul,
    input  logic               halt_req,
    input  logic               resume,
    output logic               halted,
    output logic [CNT_W-1:0]   fetch_cnt
);

    // Handshake: the output stage transfers on a cycle where out_valid and
    // out_ready are both high; out_valid never drops without a transfer.
    fetch_state_e       state_q, state_d;
    logic               out_valid_q, out_valid_d;
    logic [INSTR_W-1:0] out_instr_q, out_instr_d;
    logic [ADDR_W-1:0]  out_pc_q, out_pc_d;
    logic               annul_q, annul_d;
    logic [CNT_W-1:0]   fetch_cnt_q, fetch_cnt_d;
    logic               fire;
    logic               redir_annul;
    logic [ADDR_W-1:0]  pc;
    redirect_t          br_in;

    assign br_in = '{valid: br_valid, target: br_target, annul: br_annul};

    pc_pair #(
        .ADDR_W   (ADDR_W),
        .RESET_PC (RESET_PC)
    ) u_pc_pair (
        .clk         (clk),
        .rst         (reset),
        .fire        (fire),
        .br_in       (br_in),
        .pc          (pc),
        .redir_annul (redir_annul)
    );

    always_comb begin
        fire        = (state_q == RUN) && (!out_valid_q || out_ready);
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_instr_d = out_instr_q;
        out_pc_d    = out_pc_q;
        annul_d     = annul_q;
        fetch_cnt_d = fetch_cnt_q;

        case (state_q)
            IDLE:    state_d = RUN;
            RUN:     if (halt_req) state_d = HALT;
            HALT:    if (resume) state_d = RUN;
            default: state_d = IDLE;
        endcase

        // A squashed delay slot still advances pc but never reaches decode.
        if (fire) begin
            out_valid_d = !annul_q;
            out_instr_d = imem_rd;
            out_pc_d    = pc;
            annul_d     = redir_annul;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end

        if (out_valid_q && out_ready) begin
            fetch_cnt_d = fetch_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            out_instr_q <= '0;
            out_pc_q    <= '0;
            annul_q     <= 1'b0;
            fetch_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_instr_q <= out_instr_d;
            out_pc_q    <= out_pc_d;
            annul_q     <= annul_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign imem_a    = pc;
    assign out_valid = out_valid_q;
    assign out_instr = out_instr_q;
    assign out_pc    = out_pc_q;
    assign halted    = (state_q == HALT) && !out_valid_q;
    assign fetch_cnt = fetch_cnt_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: memory word i lives at address i, and
// delivered out_pc sequences are checked against a hand-written expected queue.
module tb_fetch_sequencer;

    logic        clk;
    logic        reset;
    logic [5:0]  imem_a;
    logic [31:0] imem_rd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [5:0]  out_pc;
    logic        br_valid;
    logic [5:0]  br_target;
    logic        br_annul;
    logic        halt_req;
    logic        resume;
    logic        halted;
    logic [15:0] fetch_cnt;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_q[$];

    fetch_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .imem_a    (imem_a),
        .imem_rd   (imem_rd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .br_valid  (br_valid),
        .br_target (br_target),
        .br_annul  (br_annul),
        .halt_req  (halt_req),
        .resume    (resume),
        .halted    (halted),
        .fetch_cnt (fetch_cnt)
    );

    assign imem_rd = {26'd0, imem_a};

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reset, release, and step to the first delivered instruction (pc 0).
    task automatic do_reset();
        reset     = 1'b1;
        out_ready = 1'b0;
        br_valid  = 1'b0;
        br_target = '0;
        br_annul  = 1'b0;
        halt_req  = 1'b0;
        resume    = 1'b0;
        tick();
        tick();
        reset     = 1'b0;
        out_ready = 1'b1;
        tick();
        check("idle_no_valid", {31'd0, out_valid}, 32'd0);
        tick();
        check("first_valid", {31'd0, out_valid}, 32'd1);
        check("first_pc", {26'd0, out_pc}, 32'd0);
    endtask

    task automatic advance_to(input logic [5:0] target);
        for (int i = 0; i < 100; i++) begin
            if (out_valid && out_pc == target) break;
            tick();
        end
        check("advance_to", {26'd0, out_pc}, {26'd0, target});
    endtask

    // Scoreboard: pop one expected pc per delivered (valid) output cycle.
    task automatic expect_seq(input string tag);
        logic [31:0] exp;
        int budget;
        budget = 60;
        while (exp_q.size() > 0 && budget > 0) begin
            if (out_valid) begin
                exp = exp_q.pop_front();
                check(tag, {26'd0, out_pc}, exp);
                check({tag, "_instr"}, out_instr, exp);
                if (exp_q.size() == 0) break;
            end
            tick();
            budget--;
        end
        if (exp_q.size() != 0) begin
            check({tag, "_timeout"}, exp_q.size(), 32'd0);
            exp_q.delete();
        end
    endtask

    initial begin
        reset     = 1'b1;
        out_ready = 1'b0;
        br_valid  = 1'b0;
        br_target = '0;
        br_annul  = 1'b0;
        halt_req  = 1'b0;
        resume    = 1'b0;
        tick();
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_instr", out_instr, 32'd0);
        check("rst_pc", {26'd0, out_pc}, 32'd0);
        check("rst_halted", {31'd0, halted}, 32'd0);
        check("rst_cnt", {16'd0, fetch_cnt}, 32'd0);
        check("rst_imem_a", {26'd0, imem_a}, 32'd0);

        // sequential stream
        do_reset();
        for (int i = 0; i < 10; i++) exp_q.push_back(i);
        expect_seq("seq");
        tick();
        check("seq_cnt10", {16'd0, fetch_cnt}, 32'd10);

        // redirect, delay slot delivered
        do_reset();
        advance_to(6'd4);
        br_valid = 1'b1; br_target = 6'd20; br_annul = 1'b0;
        tick();
        br_valid = 1'b0;
        exp_q.push_back(5); exp_q.push_back(6); exp_q.push_back(20); exp_q.push_back(21);
        expect_seq("br");
        check("br_cnt", {16'd0, fetch_cnt}, 32'd8);

        // redirect with annulled delay slot
        do_reset();
        advance_to(6'd4);
        br_valid = 1'b1; br_target = 6'd20; br_annul = 1'b1;
        tick();
        br_valid = 1'b0; br_annul = 1'b0;
        check("annul_pc5", {26'd0, out_pc}, 32'd5);
        tick();
        check("annul_slot_valid", {31'd0, out_valid}, 32'd0);
        check("annul_slot_pc", {26'd0, out_pc}, 32'd6);
        exp_q.push_back(20); exp_q.push_back(21);
        expect_seq("annul");
        check("annul_cnt", {16'd0, fetch_cnt}, 32'd7);

        // backpressure with pending redirect; the later request wins
        do_reset();
        advance_to(6'd9);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("hold_pc", {26'd0, out_pc}, 32'd9);
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_imem_a", {26'd0, imem_a}, 32'd10);
        end
        br_valid = 1'b1; br_target = 6'd30;
        tick();
        br_target = 6'd40;
        tick();
        br_valid = 1'b0;
        check("hold_br_pc", {26'd0, out_pc}, 32'd9);
        check("hold_br_imem_a", {26'd0, imem_a}, 32'd10);
        out_ready = 1'b1;
        exp_q.push_back(9); exp_q.push_back(10); exp_q.push_back(11); exp_q.push_back(40);
        expect_seq("pend");

        // address wrap 63 -> 0
        do_reset();
        br_valid = 1'b1; br_target = 6'd60;
        tick();
        br_valid = 1'b0;
        exp_q.push_back(1); exp_q.push_back(2);
        for (int i = 60; i < 64; i++) exp_q.push_back(i);
        exp_q.push_back(0); exp_q.push_back(1);
        expect_seq("wrap");

        // halt (with simultaneous resume, halt wins in RUN), drain, resume
        do_reset();
        advance_to(6'd3);
        halt_req = 1'b1; resume = 1'b1;
        tick();
        halt_req = 1'b0; resume = 1'b0;
        out_ready = 1'b0;
        check("halt_pc4", {26'd0, out_pc}, 32'd4);
        for (int i = 0; i < 2; i++) begin
            tick();
            check("halt_not_drained", {31'd0, halted}, 32'd0);
            check("halt_hold_valid", {31'd0, out_valid}, 32'd1);
        end
        out_ready = 1'b1;
        tick();
        check("halt_drained_valid", {31'd0, out_valid}, 32'd0);
        check("halted_set", {31'd0, halted}, 32'd1);
        tick();
        check("halted_stays", {31'd0, halted}, 32'd1);
        check("halt_no_fetch", {31'd0, out_valid}, 32'd0);
        check("halt_imem_a", {26'd0, imem_a}, 32'd5);
        halt_req = 1'b1; resume = 1'b1;
        tick();
        halt_req = 1'b0; resume = 1'b0;
        check("resume_halted", {31'd0, halted}, 32'd0);
        exp_q.push_back(5); exp_q.push_back(6);
        expect_seq("resume");
        check("resume_cnt", {16'd0, fetch_cnt}, 32'd6);

        // asynchronous reset mid-stream
        #3;
        reset = 1'b1;
        #1;
        check("async_valid", {31'd0, out_valid}, 32'd0);
        check("async_cnt", {16'd0, fetch_cnt}, 32'd0);
        check("async_imem_a", {26'd0, imem_a}, 32'd0);
        do_reset();
        exp_q.push_back(0); exp_q.push_back(1);
        expect_seq("post_reset");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
